// File: rtl/mips_lite_pkg.sv
// Shared constants and types for the MIPS-Lite multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_lite_pkg;

    localparam int WIDTH     = 32;
    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/mdu_divider_if.sv
// Handshake/result bundle between the EX stage (master) and the divider (slave).
// Latency: n/a (wires only).
// Backpressure: master must hold off start while busy; starts during busy are dropped.
// Ports: start/sign/dividend/divisor from master; busy/done/div_zero/DivAns from slave.
interface mdu_divider_if #(
    parameter int WIDTH = mips_lite_pkg::WIDTH
);
    logic                 start;
    logic                 sign;
    logic [WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic                 div_zero;
    logic [2*WIDTH-1:0]   DivAns;

    modport master (
        output start, sign, dividend, divisor,
        input  busy, done, div_zero, DivAns
    );

    modport slave (
        input  start, sign, dividend, divisor,
        output busy, done, div_zero, DivAns
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on {rem, quo}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: rem_i/quo_i current partial remainder and quotient, dvs_i divisor magnitude;
//        rem_o/quo_o the values after one shift-and-trial-subtract.
module div_step #(
    parameter int WIDTH = mips_lite_pkg::WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);
    // Shifted remainder kept one bit wider so the compare never loses a carry.
    logic [WIDTH+1:0] shr;
    logic [WIDTH:0]   diff;
    logic             ge;

    assign shr   = {rem_i, quo_i[WIDTH-1]};
    assign ge    = (shr >= {2'b00, dvs_i});
    assign diff  = shr[WIDTH:0] - {1'b0, dvs_i};
    assign rem_o = ge ? diff : shr[WIDTH:0];
    assign quo_o = {quo_i[WIDTH-2:0], ge};
endmodule

// File: rtl/mdu_divider.sv
// Multi-cycle DIV/DIVU engine feeding the Hi/Lo register: DivAns = {remainder, quotient}.
// Latency: result, div_zero and done update 33 cycles after start is accepted; II 34 cycles.
// Backpressure: busy high while running; start ignored (not queued) until back in IDLE.
// Ports: clk, reset (sync, active-high), bus (mdu_divider_if.slave).
module mdu_divider #(
    parameter int WIDTH = mips_lite_pkg::WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    mdu_divider_if.slave  bus
);
    import mips_lite_pkg::*;

    // One restoring step per result bit.
    localparam int ITERS = WIDTH;
    localparam int CW    = $clog2(ITERS);

    div_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sign_q, sign_d;
    logic                neg_dd_q, neg_dd_d;
    logic                neg_dv_q, neg_dv_d;
    logic [WIDTH:0]      rem_q, rem_d;
    logic [WIDTH-1:0]    quo_q, quo_d;
    logic [WIDTH-1:0]    dvs_q, dvs_d;
    logic [2*WIDTH-1:0]  ans_q, ans_d;
    logic                dz_q, dz_d;
    logic                done_q, done_d;

    logic [WIDTH:0]      step_rem;
    logic [WIDTH-1:0]    step_quo;
    logic [WIDTH-1:0]    q_fix, r_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        neg_dd_d = neg_dd_q;
        neg_dv_d = neg_dv_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        ans_d    = ans_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        q_fix    = '0;
        r_fix    = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sign_d   = bus.sign;
                    neg_dd_d = bus.dividend[WIDTH-1];
                    neg_dv_d = bus.divisor[WIDTH-1];
                    // Magnitudes only for DIV; DIVU treats the MSB as data.
                    quo_d    = (bus.sign && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
                    dvs_d    = (bus.sign && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITERS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Quotient sign follows operand sign mismatch; remainder follows the dividend.
                q_fix   = (sign_q && (neg_dd_q ^ neg_dv_q)) ? -quo_q : quo_q;
                r_fix   = (sign_q && neg_dd_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                ans_d   = {r_fix, q_fix};
                dz_d    = (dvs_q == '0);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            neg_dd_q <= 1'b0;
            neg_dv_q <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            ans_q    <= '0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            neg_dd_q <= neg_dd_d;
            neg_dv_q <= neg_dv_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            ans_q    <= ans_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.DivAns   = ans_q;
endmodule

// File: tb/tb_mdu_divider.sv
// Self-checking bench for mdu_divider: directed cases plus random operands.
// Latency: checks 33-cycle result latency and 34-cycle back-to-back spacing.
// Backpressure: exercises start-while-busy and start in the done cycle.
module tb_mdu_divider;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc_now = 0;

    mdu_divider_if #(.WIDTH(32)) bus ();

    mdu_divider #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_now++;

    // Reference result from plain arithmetic: {remainder, quotient}.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        longint      sa;
        longint      sb;
        if (b == 32'd0) begin
            // All-ones quotient magnitude, remainder magnitude = |a|, then sign fix.
            r = a;
            q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
        return {r, q};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc_now, act, exp);
        end
    endtask

    // Cycle-level expectation: result appears 33 edges after an accepted start.
    logic        m_valid = 1'b0;
    logic        m_busy  = 1'b0;
    logic        m_done  = 1'b0;
    logic        m_dz    = 1'b0;
    logic        m_pdz   = 1'b0;
    logic [63:0] m_ans   = '0;
    logic [63:0] m_pend  = '0;
    int          m_left  = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_dz    = 1'b0;
            m_ans   = '0;
            m_left  = 0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = 1'b0;
            if (m_left == 0) begin
                m_ans  = m_pend;
                m_dz   = m_pdz;
                m_done = 1'b1;
                m_busy = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (bus.start) begin
                m_pend = ref_div(bus.sign, bus.dividend, bus.divisor);
                m_pdz  = (bus.divisor == 32'd0);
                m_left = 33;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy",     {63'd0, bus.busy},     {63'd0, m_busy});
            chk("done",     {63'd0, bus.done},     {63'd0, m_done});
            chk("div_zero", {63'd0, bus.div_zero}, {63'd0, m_dz});
            chk("DivAns",   bus.DivAns,            m_ans);
        end
    end

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.start    = 1'b1;
        bus.sign     = s;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #2;
        bus.start    = 1'b0;
    endtask

    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input logic exp_dz, input string nm,
                         output int t_done);
        int t0;
        int n;
        issue(s, a, b);
        t0 = cyc_now;
        n  = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        t_done = cyc_now;
        chk({nm, "_lat"}, 64'(cyc_now - t0), 64'd33);
        chk({nm, "_ans"}, bus.DivAns, exp);
        chk({nm, "_dz"},  {63'd0, bus.div_zero}, {63'd0, exp_dz});
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 20));
            4:       v = -32'($urandom_range(1, 20));
            default: v = 32'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        int          t1;
        int          t2;
        int          dc;
        logic [63:0] seen;
        logic        rs;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.start    = 1'b0;
        bus.sign     = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        chk("rst_ans",  bus.DivAns, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);

        // Pin the reference model against hand-computed values.
        chk("ref_m7_2",   ref_div(1'b1, 32'hFFFF_FFF9, 32'd2),         64'hFFFF_FFFF_FFFF_FFFD);
        chk("ref_7_m2",   ref_div(1'b1, 32'd7, 32'hFFFF_FFFE),         64'h0000_0001_FFFF_FFFD);
        chk("ref_ovf",    ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        chk("ref_dz",     ref_div(1'b0, 32'h1234, 32'd0),              64'h0000_1234_FFFF_FFFF);

        // Reset in the middle of a division.
        issue(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
        chk("midrst_done", {63'd0, bus.done}, 64'd0);
        chk("midrst_ans",  bus.DivAns, 64'd0);
        do_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, "divu_100_7", t1);

        // Unsigned plus stability over idle cycles.
        do_op(1'b0, 32'hFFFF_FFFF, 32'h10, {32'h0000_000F, 32'h0FFF_FFFF}, 1'b0, "divu_max_16", t1);
        repeat (50) @(posedge clk);
        #2 chk("hold_50", bus.DivAns, {32'h0000_000F, 32'h0FFF_FFFF});

        // Signed operand-sign combinations.
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, "div_m7_2",  t1);
        do_op(1'b1, 32'd7,          32'hFFFF_FFFE, {32'd1,          32'hFFFF_FFFD}, 1'b0, "div_7_m2",  t1);
        do_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'd3},          1'b0, "div_m7_m2", t1);

        // Divide by zero, then a normal divide clears the flag.
        do_op(1'b0, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 1'b1, "divu_dz", t1);
        do_op(1'b0, 32'd9,    32'd3, {32'd0,    32'd3},         1'b0, "divu_9_3", t1);

        // Signed overflow wraps silently.
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0, "div_ovf", t1);

        // Start pulsed while busy is ignored.
        issue(1'b0, 32'd1000, 32'd10);
        repeat (5) @(posedge clk);
        #2 issue(1'b0, 32'd5, 32'd5);
        dc   = 0;
        seen = '0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #2;
            if (bus.done === 1'b1) begin
                dc++;
                seen = bus.DivAns;
            end
        end
        chk("busy_start_pulses", 64'(dc), 64'd1);
        chk("busy_start_ans",    seen, {32'd0, 32'd100});

        // Back-to-back: second start issued in the done cycle.
        do_op(1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0, "b2b_first", t1);
        do_op(1'b0, 32'd50, 32'd6, {32'd2, 32'd8}, 1'b0, "b2b_second", t2);
        chk("b2b_spacing", 64'(t2 - t1), 64'd34);

        // Random operands against the reference model.
        for (int k = 0; k < 60; k++) begin
            rs = 1'($urandom_range(0, 1));
            ra = pick();
            rb = pick();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            do_op(rs, ra, rb, ref_div(rs, ra, rb), (rb == 32'd0), "rand", t1);
        end

        repeat (3) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
